// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial add/subtract controller.
package adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic int unsigned nib_count(input int unsigned width);
        return width / NIBBLE_W;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned width);
        int unsigned n;
        n = nib_count(width);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_adder.sv
// 4-bit two's-complement ripple adder with carry out and signed overflow.
module nibble_adder
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout,
    output logic                overflow
);

    always_comb begin
        logic carry;
        logic carry_msb;
        carry     = cin;
        carry_msb = 1'b0;
        sum       = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            if (i == NIBBLE_W - 1) begin
                carry_msb = carry;
            end
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout     = carry;
        overflow = carry_msb ^ carry;
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// WIDTH-bit add/subtract sequenced through one shared nibble adder, LSB nibble first,
// with valid/ready handshakes on operands and result.
module serial_add_ctrl
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned NIB = nib_count(WIDTH);
    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

    state_e                          state_q, state_d;
    logic   [CNT_W-1:0]              cnt_q, cnt_d;
    logic                            carry_q, carry_d;
    logic   [NIB-1:0][NIBBLE_W-1:0]  op_a_q, op_a_d;
    logic   [NIB-1:0][NIBBLE_W-1:0]  op_b_q, op_b_d;
    logic   [NIB-1:0][NIBBLE_W-1:0]  sum_q, sum_d;
    logic                            cout_q, cout_d;
    logic                            ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic                nib_ovf;

    nibble_adder u_nibble_adder (
        .a        (op_a_q[cnt_q]),
        .b        (op_b_q[cnt_q]),
        .cin      (carry_q),
        .sum      (nib_sum),
        .cout     (nib_cout),
        .overflow (nib_ovf)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Subtract as A + ~B + 1; a set cin then cancels that +1 (borrow in).
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[cnt_q] = nib_sum;
                carry_d      = nib_cout;
                if (cnt_q == LAST_NIB) begin
                    cout_d  = nib_cout;
                    ovf_d   = nib_ovf;
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StRun) || (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed checks of serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                         input logic tc, output logic [W-1:0] es, output logic eco,
                         output logic eov);
        longint ua, ub, sa, sb, c, u, sr;
        ua = longint'(ta);
        ub = longint'(tb);
        sa = $signed(ta);
        sb = $signed(tb);
        c  = tc ? 64'sd1 : 64'sd0;
        if (!ts) begin
            u   = ua + ub + c;
            sr  = sa + sb + c;
            eco = (u > 65535);
        end else begin
            u   = ua - ub - c;
            sr  = sa - sb - c;
            eco = (ua >= ub + c);
        end
        es  = u[W-1:0];
        eov = (sr > 32767) || (sr < -32768);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                          input logic tc, input int bp, input string name);
        logic [W-1:0] es;
        logic         eco, eov;
        int           lat;
        model(ta, tb, ts, tc, es, eco, eov);

        check($sformatf("%s/idle_ready", name), 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = ta;
        b = tb;
        sub = ts;
        cin = tc;
        tick();
        // Operands change right after accept; the result must not depend on them.
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        sub = 1'($urandom);
        cin = 1'($urandom);
        check($sformatf("%s/run_ready", name), 32'(in_ready), 32'd0);
        check($sformatf("%s/run_busy", name), 32'(busy), 32'd1);

        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check($sformatf("%s/latency", name), 32'(lat), 32'(NIB));
        check($sformatf("%s/sum", name), 32'(sum), 32'(es));
        check($sformatf("%s/cout", name), 32'(cout), 32'(eco));
        check($sformatf("%s/ovf", name), 32'(overflow), 32'(eov));
        check($sformatf("%s/done_busy", name), 32'(busy), 32'd1);

        for (int i = 0; i < bp; i++) begin
            in_valid = 1'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            tick();
            check($sformatf("%s/bp_valid", name), 32'(out_valid), 32'd1);
            check($sformatf("%s/bp_ready", name), 32'(in_ready), 32'd0);
            check($sformatf("%s/bp_res", name), {14'd0, cout, overflow, sum},
                  {14'd0, eco, eov, es});
        end

        // Handoff edge with in_valid also high: only the handoff is taken.
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 16'($urandom);
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        check($sformatf("%s/post_valid", name), 32'(out_valid), 32'd0);
        check($sformatf("%s/post_ready", name), 32'(in_ready), 32'd1);
        check($sformatf("%s/post_busy", name), 32'(busy), 32'd0);
    endtask

    initial begin
        logic seen;
        #1;
        check("rst/in_ready", 32'(in_ready), 32'd1);
        check("rst/out_valid", 32'(out_valid), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/res", {14'd0, cout, overflow, sum}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, "add_5555");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "add_ffff");
        run_op(16'h00FF, 16'h0000, 1'b0, 1'b1, 0, "add_cin");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "add_ovf");
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, "add_neg_ovf");
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 0, "sub_neg");
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 0, "sub_ovf");
        run_op(16'h0010, 16'h0001, 1'b1, 1'b1, 0, "sub_borrow");
        run_op(16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 3, "backpressure");

        // Abort in the middle of RUN (two nibbles already done).
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h1111;
        sub = 1'b0;
        cin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort/in_ready", 32'(in_ready), 32'd1);
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/out_valid", 32'(out_valid), 32'd0);
        check("abort/res", {14'd0, cout, overflow, sum}, 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | out_valid;
        end
        check("abort/no_result", 32'(seen), 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, "after_abort");

        for (int i = 0; i < 40; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencing controller that performs WIDTH-bit two's-complement add/subtract by time-multiplexing one 4-bit ripple adder, one nibble per clock, LSB nibble first.
- Carry is registered between nibbles.
- Valid/ready handshake on operand input and on result output.
- Sits between the register-file/ALU front end and the shared 4-bit adder datapath; one operation in flight at a time.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived; number of nibble passes per operation. Not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  controller idle and able to accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  1 = A − B, 0 = A + B.
- cin  input  1  carry in (add) / borrow in (sub).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB nibble (for sub: 1 = no borrow).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB, taken on the last nibble.
- busy  output  1  high in RUN and DONE.

Behaviour:
- States:
  - IDLE: in_ready=1, busy=0.
  - RUN: in_ready=0, busy=1.
  - DONE: out_valid=1, busy=1.
- Reset (async, rst_n=0): state=IDLE, nibble counter=0, carry reg=0, sum=0, cout=0, overflow=0, out_valid=0, busy=0; in_ready=1 as soon as reset is applied.
- Accept: in IDLE, in_valid=1 on a rising edge →
  - latch a into opA, and b into opB (b inverted when sub=1);
  - carry_reg = cin XOR sub;
  - counter=0; go to RUN.
  - Effective results: add = A+B+cin; sub = A−B−cin.
- RUN, each cycle k = 0..NIB-1:
  - adder inputs = opA[4k+3:4k], opB[4k+3:4k], carry_reg;
  - sum[4k+3:4k] <= adder Sum; carry_reg <= adder cout; counter++.
- Last nibble (k=NIB-1): cout <= adder cout, overflow <= adder overflow, state → DONE.
- Latency: out_valid rises exactly NIB rising edges after the accepting edge (4 for WIDTH=16).
- DONE: sum/cout/overflow held stable while out_valid=1 and out_ready=0 (unbounded backpressure). On an edge with out_ready=1 → IDLE; out_valid drops and in_ready rises the next cycle.
- No back-to-back overlap: an accept earliest one cycle after result handoff.
- sum bits beyond nibble k are undefined/stale during RUN; consumers use only out_valid-qualified values.
- in_valid, a, b, sub, cin are ignored outside IDLE; operand changes after accept have no effect.
- Counter width = clog2(NIB); the counter never wraps past NIB-1, because the state exits RUN on the last nibble.
- Reset mid-operation (any state): immediate abort to reset values; no out_valid is produced for the aborted operation.
- Simultaneous in_valid and out_ready in DONE: out_ready handled; in_valid not accepted that edge.

Decomposition:
- Shared package (adder_pkg):
  - state enum {IDLE, RUN, DONE};
  - NIBBLE_W=4;
  - function computing NIB/counter width.
- Sub-module: nibble_adder, the team's existing 4-bit two's-complement ripple adder (A, B, cin → Sum, cout, overflow). Instantiated once; controller holds FSM, operand regs, counter, carry reg, result reg.

Test Plan (WIDTH=16):
- 0x1234+0x4321, sub=0, cin=0 → sum=0x5555, cout=0, overflow=0; out_valid exactly 4 edges after accept; in_ready low for RUN+DONE.
- 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1, overflow=0 (carry propagates through all 4 nibble passes); 0x00FF+0x0000, cin=1 → 0x0100.
- 0x7FFF+0x0001 → sum=0x8000, cout=0, overflow=1; 0x8000+0x8000 → sum=0x0000, cout=1, overflow=1.
- sub=1: 0x0005−0x0007, cin=0 → 0xFFFE, cout=0, overflow=0; 0x8000−0x0001 → 0x7FFF, cout=1, overflow=1; 0x0010−0x0001 with cin=1 → 0x000E.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid/a/b → sum/cout/overflow stable, no new accept; out_ready=1 → IDLE, next in_valid accepted one cycle later.
- Assert rst_n=0 during RUN nibble 2 → outputs go to reset values immediately; after release, in_ready=1, no out_valid; the following 0x0001+0x0001 yields 0x0002.
